mips_fetch_stage: RTL

- Instruction-fetch stage of the stalling pipelined MIPS core; sits directly upstream of instruction decode.
- Owns the PC register, the next-PC selection and the IF/ID pipeline register.
- Drives `inst_addr` to the instruction memory and consumes the returned `inst`.
- Detects end-of-program (a run of zero instructions) and freezes fetch.

---
 rtl/mips_pkg.sv | 15 +
 rtl/fetch_halt_detect.sv | 55 +++++
 rtl/mips_fetch_stage.sv | 105 ++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch stage.
package mips_pkg;

    localparam int unsigned WORD_WIDTH       = 32;
    localparam int unsigned MEM_ADDR_WIDTH   = 32;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } halt_state_e;

endpackage

// File: rtl/fetch_halt_detect.sv
// End-of-program detector: counts consecutive zero fetches and latches halt
// once HALT_COUNT of them have been seen; only reset leaves HALT.
module fetch_halt_detect
    import mips_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = mips_pkg::WORD_WIDTH,
    parameter int unsigned HALT_COUNT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] inst,
    input  logic                  stall,
    input  logic                  redirect,
    output logic                  halted
);

    localparam int unsigned   CW   = $clog2(HALT_COUNT + 1);
    localparam logic [CW-1:0] CMAX = CW'(HALT_COUNT);

    halt_state_e   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Stalled cycles re-present the same word, so only advancing cycles count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == RUN) begin
            if (redirect) begin
                cnt_d = '0;
            end else if (!stall) begin
                if (inst == WORD_WIDTH'(NOP_INST)) begin
                    cnt_d = (cnt_q == CMAX) ? CMAX : cnt_q + 1'b1;
                end else begin
                    cnt_d = '0;
                end
            end
            if (cnt_d == CMAX) begin
                state_d = HALT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halted = (state_q == HALT);

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, IF/ID register.
// Optional perf counters built only when MIPS_FETCH_PERF_EN is defined.
module mips_fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned            WORD_WIDTH = mips_pkg::WORD_WIDTH,
    parameter logic [WORD_WIDTH-1:0]  RESET_PC   = WORD_WIDTH'(DEFAULT_RESET_PC),
    parameter int unsigned            HALT_COUNT = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WORD_WIDTH-1:0] inst,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [WORD_WIDTH-1:0] redirect_pc,
    output logic [WORD_WIDTH-1:0] inst_addr,
    output logic [WORD_WIDTH-1:0] pc_IF,
    output logic [WORD_WIDTH-1:0] pc_ID,
    output logic [WORD_WIDTH-1:0] inst_ID,
    output logic                  halted,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
);

    logic [WORD_WIDTH-1:0] pc_q;
    logic [WORD_WIDTH-1:0] next_pc;
    logic [WORD_WIDTH-1:0] pc_id_q;
    logic [WORD_WIDTH-1:0] inst_id_q;

    fetch_halt_detect #(
        .WORD_WIDTH (WORD_WIDTH),
        .HALT_COUNT (HALT_COUNT)
    ) u_halt (
        .clk      (clk),
        .rst      (rst),
        .inst     (inst),
        .stall    (stall),
        .redirect (redirect),
        .halted   (halted)
    );

    // Next PC drives instmem directly so its registered read lines up with pc_IF.
    always_comb begin
        if (rst) begin
            next_pc = RESET_PC;
        end else if (halted) begin
            next_pc = pc_q;
        end else if (redirect) begin
            next_pc = {redirect_pc[WORD_WIDTH-1:2], 2'b00};
        end else if (stall) begin
            next_pc = pc_q;
        end else begin
            next_pc = pc_q + WORD_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= next_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect) begin
            inst_id_q <= '0;
            pc_id_q   <= '0;
        end else if (!(stall || halted)) begin
            inst_id_q <= inst;
            pc_id_q   <= pc_q;
        end
    end

    assign inst_addr = next_pc;
    assign pc_IF     = pc_q;
    assign pc_ID     = pc_id_q;
    assign inst_ID   = inst_id_q;

`ifdef MIPS_FETCH_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !redirect && !halted && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
